// File: rtl/if_id_fetch_queue.sv
// Fetch-to-decode instruction queue: buffers {pc, instr} pairs from fetch,
// presents the head to decode first-word-fall-through, and throttles fetch via a registered stall.
module if_id_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter int          AW        = 2,
    parameter int          SKID      = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [31:0]   pc_i,
    input  logic [31:0]   instr_i,
    input  logic          valid_i,
    input  logic          flush_i,
    output logic          stall_o,
    output logic [31:0]   pc_o,
    output logic [31:0]   instr_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [AW:0]   count_o,
    output logic          overflow_o
);

    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_CNT = (AW+1)'(DEPTH - SKID);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          stall_q;
    logic          overflow_q;

    logic          pop;
    logic          push;
    logic          drop;
    logic [AW:0]   count_next;
    logic [63:0]   head;

    always_comb begin
        pop        = valid_o & ready_i & ~flush_i;
        push       = valid_i & ~flush_i & ((count < FULL_CNT) | pop);
        drop       = valid_i & ~flush_i & ~push;
        count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Storage carries no reset; only pointers and flags are initialised.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {pc_i, instr_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (flush_i) begin
            // Redirect: everything buffered or arriving this cycle is wrong-path.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            stall_q    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count_next;
            stall_q <= (count_next >= STALL_CNT);
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_comb begin
        head    = mem[rd_ptr];
        valid_o = (count != '0);
        pc_o    = valid_o ? head[63:32] : 32'h0;
        instr_o = valid_o ? head[31:0]  : NOP_INSTR;
    end

    assign stall_o    = stall_q;
    assign count_o    = count;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Scoreboard bench for if_id_fetch_queue: stimulus pushes expected entries, a monitor checks pops.
module tb_if_id_fetch_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] pc_i = '0;
    logic [31:0] instr_i = '0;
    logic        valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [2:0]  count_o;
    logic        overflow_o;

    if_id_fetch_queue dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .instr_i(instr_i),
        .valid_i(valid_i), .flush_i(flush_i), .stall_o(stall_o),
        .pc_o(pc_o), .instr_o(instr_o), .valid_o(valid_o), .ready_i(ready_i),
        .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    // Reference occupancy model
    int   mcount = 0;
    logic movf   = 1'b0;
    logic mstall = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_unexpected: got pc=%h instr=%h, required no entry", pc_o, instr_o);
            end else begin
                chk("pop_entry", {pc_o, instr_o}, exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic rs, input logic v, input logic [31:0] p,
                        input logic [31:0] ins, input logic r, input logic f);
        logic mpop, mpush;
        rst_i = rs; valid_i = v; pc_i = p; instr_i = ins; ready_i = r; flush_i = f;
        if (rs) begin
            mcount = 0; movf = 1'b0; mstall = 1'b0; exp_q.delete();
        end else if (f) begin
            mcount = 0; mstall = 1'b0; exp_q.delete();
        end else begin
            mpop  = (mcount != 0) && r;
            mpush = v && ((mcount < 4) || mpop);
            if (mpush) exp_q.push_back({p, ins});
            if (v && !mpush) movf = 1'b1;
            mcount = mcount + int'(mpush) - int'(mpop);
            mstall = (mcount >= 2);
        end
        @(posedge clk_i);
        #1;
        chk("count", 64'(count_o), 64'(mcount));
        chk("valid", 64'(valid_o), 64'(mcount != 0));
        chk("stall", 64'(stall_o), 64'(mstall));
        chk("overflow", 64'(overflow_o), 64'(movf));
        if (mcount == 0) chk("empty_out", {pc_o, instr_o}, {32'h0, NOP});
    endtask

    initial begin
        // Reset
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_pc", 64'(pc_o), 64'h0);
        chk("rst_instr", 64'(instr_o), 64'(NOP));

        // Three pushes with decode stalled
        step(0, 1, 32'h0, 32'h00100093, 0, 0);
        chk("stall_c1", 64'(stall_o), 64'h0);
        step(0, 1, 32'h4, 32'h00200113, 0, 0);
        chk("stall_c2", 64'(stall_o), 64'h1);
        step(0, 1, 32'h8, 32'h00300193, 0, 0);
        chk("count3", 64'(count_o), 64'd3);
        step(0, 0, 0, 0, 0, 0);
        chk("head_hold", {pc_o, instr_o}, {32'h0, 32'h00100093});

        // Drain
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
        chk("drained_instr", 64'(instr_o), 64'(NOP));

        // Fill, then push+pop while full
        for (int i = 0; i < 4; i++) step(0, 1, 32'h10 + 32'(4*i), 32'hA000_0000 + 32'(i), 0, 0);
        chk("full4", 64'(count_o), 64'd4);
        step(0, 1, 32'h20, 32'hA000_0004, 1, 0);
        chk("full_pushpop_cnt", 64'(count_o), 64'd4);
        chk("full_pushpop_ovf", 64'(overflow_o), 64'h0);

        // Push into a full queue with no pop: dropped
        step(0, 1, 32'h24, 32'hDEAD_BEEF, 0, 0);
        chk("drop_ovf", 64'(overflow_o), 64'h1);
        chk("drop_head", 64'(pc_o), 64'h14);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);

        // Flush with a concurrent push and pop
        for (int i = 0; i < 3; i++) step(0, 1, 32'h30 + 32'(4*i), 32'hB000_0000 + 32'(i), 0, 0);
        step(0, 1, 32'h3C, 32'hBAD0_0000, 1, 1);
        chk("flush_valid", 64'(valid_o), 64'h0);
        chk("flush_ovf_sticky", 64'(overflow_o), 64'h1);
        step(0, 1, 32'h40, 32'hC000_0000, 0, 0);
        chk("post_flush_head", {pc_o, instr_o}, {32'h40, 32'hC000_0000});
        step(0, 0, 0, 0, 1, 0);

        // Reset mid-stream wins over flush
        step(0, 1, 32'h50, 32'hD000_0000, 0, 0);
        step(0, 1, 32'h54, 32'hD000_0001, 0, 0);
        step(1, 1, 32'h58, 32'hD000_0002, 1, 1);
        chk("rst_ovf_clear", 64'(overflow_o), 64'h0);
        step(0, 1, 32'h60, 32'hE000_0000, 0, 0);
        step(0, 1, 32'h64, 32'hE000_0001, 1, 0);
        chk("resume_head", 64'(pc_o), 64'h64);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
